fifo_sync_param: RTL and testbench

Parametrised synchronous FIFO and the next generation of the team's fixed 1024x32 FIFO. Width, depth, almost-full and almost-empty thresholds, and read mode are all generic. It adds a fill count, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) mode. It sits between producer and consumer blocks in one clock domain, as a drop-in buffer for datapath and test-harness models.

---
 rtl/fifo_sync_param_pkg.sv | 20 ++
 rtl/fifo_ram_sdp.sv | 34 +++
 rtl/fifo_sync_param.sv | 138 +++++++++++++
 tb/tb_fifo_sync_param.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Default geometry matches the legacy 1024x32 FIFO.
package fifo_sync_param_pkg;

    localparam int unsigned FIFO_WIDTH_DEF     = 32;
    localparam int unsigned FIFO_ADDR_BITS_DEF = 10;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: synchronous write, synchronous registered read.
// Storage is deliberately unreset so it maps onto a RAM macro.
module fifo_ram_sdp
    import fifo_sync_param_pkg::*;
#(
    parameter int unsigned WIDTH     = FIFO_WIDTH_DEF,
    parameter int unsigned ADDR_BITS = FIFO_ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with fill count, sticky error flags and
// optional first-word-fall-through read mode.
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int unsigned WIDTH        = FIFO_WIDTH_DEF,
    parameter int unsigned ADDR_BITS    = FIFO_ADDR_BITS_DEF,
    parameter int unsigned AFULL_LEVEL  = (1 << ADDR_BITS) - 4,
    parameter int unsigned AEMPTY_LEVEL = 4,
    parameter bit          FWFT         = 1'b0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [WIDTH-1:0]     din,
    input  logic                 writep,
    input  logic                 readp,
    input  logic                 clr_errp,
    output logic [WIDTH-1:0]     dout,
    output logic                 emptyp,
    output logic                 fullp,
    output logic                 afullp,
    output logic                 aemptyp,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflowp,
    output logic                 underflowp
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = clog2(DEPTH + 1);

    logic [ADDR_BITS-1:0] r_head;
    logic [ADDR_BITS-1:0] r_tail;
    logic [CNT_W-1:0]     r_count;
    logic                 r_valid;
    logic                 r_rd_seen;
    logic                 r_ovf;
    logic                 r_unf;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic [CNT_W-1:0]     w_ram_cnt;
    logic                 w_ram_has;
    logic                 w_load;
    logic                 w_valid_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 w_ovf_nxt;
    logic                 w_unf_nxt;
    logic [WIDTH-1:0]     w_rdata;

    // Status decodes and accept qualification from registered state only.
    always_comb begin
        w_full    = (r_count == CNT_W'(DEPTH));
        w_empty   = FWFT ? ~r_valid : (r_count == '0);
        w_wr_acc  = writep & ~w_full;
        w_rd_acc  = readp & ~w_empty;
        w_ram_cnt = r_count - CNT_W'(r_valid);
        w_ram_has = (w_ram_cnt != '0);
    end

    // In FWFT mode the RAM read register doubles as the output holding
    // register: refill it whenever it is free or being consumed.
    always_comb begin
        w_load      = w_rd_acc;
        w_valid_nxt = 1'b0;
        if (FWFT) begin
            w_load = (~r_valid | w_rd_acc) & w_ram_has;
            if (w_load) begin
                w_valid_nxt = 1'b1;
            end else if (w_rd_acc) begin
                w_valid_nxt = 1'b0;
            end else begin
                w_valid_nxt = r_valid;
            end
        end
    end

    // Fill count and sticky error flags; a set beats a coincident clear.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        w_ovf_nxt = (writep & w_full)  | (r_ovf & ~clr_errp);
        w_unf_nxt = (readp  & w_empty) | (r_unf & ~clr_errp);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_rd_seen <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_head <= r_head + ADDR_BITS'(1);
            end
            if (w_load) begin
                r_tail    <= r_tail + ADDR_BITS'(1);
                r_rd_seen <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_valid <= w_valid_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    fifo_ram_sdp #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_acc),
        .waddr (r_head),
        .wdata (din),
        .re    (w_load),
        .raddr (r_tail),
        .rdata (w_rdata)
    );

    // The RAM read register is unreset; hold dout at zero until its first load.
    assign dout       = r_rd_seen ? w_rdata : '0;
    assign emptyp     = w_empty;
    assign fullp      = w_full;
    assign afullp     = (32'(r_count) >= AFULL_LEVEL);
    assign aemptyp    = (32'(r_count) <= AEMPTY_LEVEL);
    assign count      = r_count;
    assign overflowp  = r_ovf;
    assign underflowp = r_unf;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a standard-read and an FWFT instance
// share stimulus and are each checked against a queue-based reference model.
module tb_fifo_sync_param;

    localparam int W     = 16;
    localparam int AB    = 3;
    localparam int DEPTH = 8;
    localparam int AFL   = 4;
    localparam int AEL   = 2;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b1;
    logic [W-1:0]  din      = '0;
    logic          writep   = 1'b0;
    logic          readp    = 1'b0;
    logic          clr_errp = 1'b0;

    logic [W-1:0]  dout0, dout1;
    logic          emptyp0, fullp0, afullp0, aemptyp0, ovf0, unf0;
    logic          emptyp1, fullp1, afullp1, aemptyp1, ovf1, unf1;
    logic [AB:0]   count0, count1;

    fifo_sync_param #(.WIDTH(W), .ADDR_BITS(AB), .AFULL_LEVEL(AFL),
                      .AEMPTY_LEVEL(AEL), .FWFT(1'b0)) u_std (
        .clk(clk), .rstn(rstn), .din(din), .writep(writep), .readp(readp),
        .clr_errp(clr_errp), .dout(dout0), .emptyp(emptyp0), .fullp(fullp0),
        .afullp(afullp0), .aemptyp(aemptyp0), .count(count0),
        .overflowp(ovf0), .underflowp(unf0));

    fifo_sync_param #(.WIDTH(W), .ADDR_BITS(AB), .AFULL_LEVEL(AFL),
                      .AEMPTY_LEVEL(AEL), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rstn(rstn), .din(din), .writep(writep), .readp(readp),
        .clr_errp(clr_errp), .dout(dout1), .emptyp(emptyp1), .fullp(fullp1),
        .afullp(afullp1), .aemptyp(aemptyp1), .count(count1),
        .overflowp(ovf1), .underflowp(unf1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic [31:0]  e;
    } ent_t;

    // Reference state: held words in order, sticky errors, last read word.
    logic [W-1:0] q0[$];
    ent_t         q1[$];
    logic [W-1:0] exp0[$];
    logic [W-1:0] exp1[$];
    logic [W-1:0] m_dout0 = '0;
    bit           m_ovf0 = 0, m_unf0 = 0, m_ovf1 = 0, m_unf1 = 0, m_vis1 = 0;
    int unsigned  edge_n = 0;
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        chk("count0",  32'(count0),   32'(q0.size()));
        chk("empty0",  32'(emptyp0),  32'(q0.size() == 0));
        chk("full0",   32'(fullp0),   32'(q0.size() == DEPTH));
        chk("afull0",  32'(afullp0),  32'(q0.size() >= AFL));
        chk("aempty0", 32'(aemptyp0), 32'(q0.size() <= AEL));
        chk("ovf0",    32'(ovf0),     32'(m_ovf0));
        chk("unf0",    32'(unf0),     32'(m_unf0));
        chk("dout0",   32'(dout0),    32'(m_dout0));
        chk("count1",  32'(count1),   32'(q1.size()));
        chk("empty1",  32'(emptyp1),  32'(!m_vis1));
        chk("full1",   32'(fullp1),   32'(q1.size() == DEPTH));
        chk("afull1",  32'(afullp1),  32'(q1.size() >= AFL));
        chk("aempty1", 32'(aemptyp1), 32'(q1.size() <= AEL));
        chk("ovf1",    32'(ovf1),     32'(m_ovf1));
        chk("unf1",    32'(unf1),     32'(m_unf1));
        if (m_vis1) chk("head1", 32'(dout1), 32'(q1[0].d));
    endtask

    // Apply one edge's worth of inputs to both models, queueing read data.
    task automatic model_step(input bit wp, input bit rp, input bit clr, input logic [W-1:0] d);
        bit   full, emp;
        ent_t x;
        edge_n++;
        full = (q0.size() == DEPTH);
        emp  = (q0.size() == 0);
        m_ovf0 = (wp && full) || (m_ovf0 && !clr);
        m_unf0 = (rp && emp)  || (m_unf0 && !clr);
        if (rp && !emp) begin
            m_dout0 = q0.pop_front();
            exp0.push_back(m_dout0);
        end
        if (wp && !full) q0.push_back(d);

        full = (q1.size() == DEPTH);
        emp  = !m_vis1;
        m_ovf1 = (wp && full) || (m_ovf1 && !clr);
        m_unf1 = (rp && emp)  || (m_unf1 && !clr);
        if (rp && !emp) begin
            x = q1.pop_front();
            exp1.push_back(x.d);
        end
        if (wp && !full) begin
            x.d = d;
            x.e = edge_n;
            q1.push_back(x);
        end
        // The head is presented once it was written at an earlier edge.
        m_vis1 = (q1.size() != 0) && (q1[0].e < edge_n);
    endtask

    task automatic cyc(input bit wp, input bit rp, input bit clr, input logic [W-1:0] d);
        @(negedge clk);
        check_flags();
        writep   = wp;
        readp    = rp;
        clr_errp = clr;
        din      = d;
        model_step(wp, rp, clr, d);
        @(posedge clk);
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
        m_dout0 = '0;
        m_ovf0 = 0; m_unf0 = 0; m_ovf1 = 0; m_unf1 = 0; m_vis1 = 0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        writep = 0; readp = 0; clr_errp = 0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_count0", 32'(count0),  0);
        chk("rst_empty0", 32'(emptyp0), 1);
        chk("rst_dout0",  32'(dout0),   0);
        chk("rst_count1", 32'(count1),  0);
        chk("rst_empty1", 32'(emptyp1), 1);
        chk("rst_dout1",  32'(dout1),   0);
        model_reset();
        @(negedge clk);
        check_flags();
        rstn = 1'b1;
    endtask

    // Standard-read monitor: read data is valid just after the accepting edge.
    always @(posedge clk) begin
        if (rstn && readp && !emptyp0) begin
            #1;
            if (exp0.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd0: unexpected read, got %0h expected none", dout0);
            end else begin
                chk("rd0", 32'(dout0), 32'(exp0.pop_front()));
            end
        end
    end

    // FWFT monitor: the consumed word is the one on dout before the edge.
    always @(posedge clk) begin
        if (rstn && readp && !emptyp1) begin
            if (exp1.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd1: unexpected read, got %0h expected none", dout1);
            end else begin
                chk("rd1", 32'(dout1), 32'(exp1.pop_front()));
            end
        end
    end

    initial begin
        int wprob, rprob;
        #1 rstn = 1'b0;
        #1;
        chk("init_count0", 32'(count0), 0);
        chk("init_empty0", 32'(emptyp0), 1);
        chk("init_aempty0", 32'(aemptyp0), 1);
        chk("init_empty1", 32'(emptyp1), 1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Fill to full, overflow, drain past empty.
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, W'(i));
        cyc(1, 0, 0, W'(8));
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, '0);
        cyc(0, 0, 1, '0);

        // Simultaneous read+write at full, then at empty.
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, W'(100 + i));
        cyc(1, 1, 0, W'(16'h77));
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, '0);
        cyc(0, 0, 1, '0);
        cyc(1, 1, 0, W'(16'h55));
        cyc(0, 1, 0, '0);
        cyc(0, 1, 0, '0);
        cyc(0, 0, 1, '0);

        // Wrap-around through depth 8.
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, W'(i));
            cyc(0, 1, 0, '0);
        end
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, '0);
        cyc(0, 0, 1, '0);

        // FWFT latency and back-to-back reads.
        cyc(1, 0, 0, W'(16'h11));
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, W'(16'h20 + i));
        cyc(0, 0, 0, '0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, '0);

        // Error clear, and set winning over a coincident clear.
        cyc(0, 0, 1, '0);
        cyc(0, 1, 0, '0);
        cyc(0, 0, 1, '0);
        cyc(0, 1, 1, '0);
        cyc(0, 0, 0, '0);

        // Reset mid-stream, then normal operation resumes.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, W'(16'h300 + i));
        do_reset();
        cyc(1, 0, 0, W'(16'hA5));
        cyc(0, 0, 0, '0);
        cyc(0, 1, 0, '0);
        cyc(0, 0, 0, '0);

        // Randomised traffic with phase-varying bias to reach both extremes.
        for (int p = 0; p < 16; p++) begin
            wprob = (p % 4 == 0) ? 85 : (p % 4 == 1) ? 20 : 50;
            rprob = (p % 4 == 0) ? 20 : (p % 4 == 1) ? 85 : 50;
            for (int i = 0; i < 100; i++) begin
                cyc($urandom_range(0, 99) < wprob, $urandom_range(0, 99) < rprob,
                    $urandom_range(0, 19) == 0, W'($urandom));
            end
        end

        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        @(negedge clk);
        check_flags();
        chk("exp0_left", 32'(exp0.size()), 0);
        chk("exp1_left", 32'(exp1.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
